// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single Avalon-MM SDRAM
//            controller. Only one command is in flight at a time.
//            Optional grant counters are enabled by the SDRAM_ARB_STATS_EN macro.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   r0_address,
    input  logic                r0_read,
    input  logic                r0_write,
    input  logic [DATA_W-1:0]   r0_writedata,
    input  logic [DATA_W/8-1:0] r0_byteenable,
    output logic                r0_waitrequest,
    output logic [DATA_W-1:0]   r0_readdata,
    output logic                r0_readdatavalid,
    input  logic [ADDR_W-1:0]   r1_address,
    input  logic                r1_read,
    input  logic                r1_write,
    input  logic [DATA_W-1:0]   r1_writedata,
    input  logic [DATA_W/8-1:0] r1_byteenable,
    output logic                r1_waitrequest,
    output logic [DATA_W-1:0]   r1_readdata,
    output logic                r1_readdatavalid,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    output logic                avm_write,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic [15:0]         stat_grants0,
    output logic [15:0]         stat_grants1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_last_grant;

    logic w_req0;
    logic w_req1;
    logic w_grant;
    logic w_issue;
    logic w_accept;
    logic w_sel_read;
    logic w_sel_write;

    assign w_req0   = r0_read | r0_write;
    assign w_req1   = r1_read | r1_write;
    // On contention the requester not served last wins; otherwise whoever asks.
    assign w_grant  = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
    assign w_issue  = (r_state == IDLE) & (w_req0 | w_req1);
    assign w_accept = (r_state == CMD) & ~avm_waitrequest;

    assign w_sel_read  = w_grant ? r1_read  : r0_read;
    assign w_sel_write = w_grant ? r1_write : r0_write;

    assign r0_readdata = avm_readdata;
    assign r1_readdata = avm_readdata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        r0_readdatavalid = 1'b0;
        r1_readdatavalid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (!avm_waitrequest) begin
                    r0_waitrequest = r_owner;
                    r1_waitrequest = ~r_owner;
                    w_state_nxt    = avm_read ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    r0_readdatavalid = ~r_owner;
                    r1_readdatavalid = r_owner;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_owner        <= 1'b0;
            r_last_grant   <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
        end else if (w_issue) begin
            r_owner        <= w_grant;
            r_last_grant   <= w_grant;
            avm_address    <= w_grant ? r1_address    : r0_address;
            avm_writedata  <= w_grant ? r1_writedata  : r0_writedata;
            avm_byteenable <= w_grant ? r1_byteenable : r0_byteenable;
            // Write takes priority; a simultaneous read stays pending.
            avm_write      <= w_sel_write;
            avm_read       <= w_sel_read & ~w_sel_write;
        end else if (w_accept) begin
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] r_grants0;
    logic [15:0] r_grants1;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_grants0 <= '0;
            r_grants1 <= '0;
        end else if (w_accept) begin
            if (!r_owner && (r_grants0 != 16'hFFFF)) begin
                r_grants0 <= r_grants0 + 16'd1;
            end
            if (r_owner && (r_grants1 != 16'hFFFF)) begin
                r_grants1 <= r_grants1 + 16'd1;
            end
        end
    end

    assign stat_grants0 = r_grants0;
    assign stat_grants1 = r_grants1;
`else
    assign stat_grants0 = 16'd0;
    assign stat_grants1 = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Purpose  : Directed self-checking bench for sdram_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n;
    logic [ADDR_W-1:0]   r0_address, r1_address;
    logic                r0_read, r0_write, r1_read, r1_write;
    logic [DATA_W-1:0]   r0_writedata, r1_writedata;
    logic [DATA_W/8-1:0] r0_byteenable, r1_byteenable;
    logic                r0_waitrequest, r1_waitrequest;
    logic [DATA_W-1:0]   r0_readdata, r1_readdata;
    logic                r0_readdatavalid, r1_readdatavalid;
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_read, avm_write;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic [15:0]         stat_grants0, stat_grants1;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
        .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
        .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
        .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
        .r1_readdatavalid(r1_readdatavalid),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_write(avm_write),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        int n0, n1, g;
        reset_reset_n     = 1'b0;
        r0_address = '0; r1_address = '0;
        r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
        r0_writedata = '0; r1_writedata = '0;
        r0_byteenable = '0; r1_byteenable = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;

        // Reset state
        nxt(); nxt();
        chk("rst_avm_write", avm_write, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_avm_writedata", avm_writedata, 0);
        chk("rst_avm_byteenable", avm_byteenable, 0);
        chk("rst_r0_waitrequest", r0_waitrequest, 1);
        chk("rst_r1_waitrequest", r1_waitrequest, 1);
        chk("rst_r0_rdv", r0_readdatavalid, 0);
        chk("rst_stat0", stat_grants0, 0);
        reset_reset_n = 1'b1;
        nxt();

        // Single write from r0
        r0_write = 1; r0_address = 25'h10; r0_writedata = 32'hDEADBEEF; r0_byteenable = 4'hF;
        #1;
        chk("wr_not_yet", avm_write, 0);
        nxt();
        chk("wr_avm_write", avm_write, 1);
        chk("wr_avm_read", avm_read, 0);
        chk("wr_avm_address", avm_address, 25'h10);
        chk("wr_avm_writedata", avm_writedata, 32'hDEADBEEF);
        chk("wr_avm_be", avm_byteenable, 4'hF);
        chk("wr_r0_waitreq", r0_waitrequest, 0);
        chk("wr_r1_waitreq", r1_waitrequest, 1);
        r0_write = 0;
        nxt();
        chk("wr_done_avm_write", avm_write, 0);
        chk("wr_done_r0_waitreq", r0_waitrequest, 1);

        // Simultaneous reads from reset: r0 first, then r1
        reset_reset_n = 0; nxt(); reset_reset_n = 1; nxt();
        r0_read = 1; r0_address = 25'h100; r1_read = 1; r1_address = 25'h200;
        nxt();
        chk("rd0_avm_read", avm_read, 1);
        chk("rd0_avm_address", avm_address, 25'h100);
        chk("rd0_r0_waitreq", r0_waitrequest, 0);
        chk("rd0_r1_waitreq", r1_waitrequest, 1);
        r0_read = 0;
        nxt();
        chk("rd0_wait_avm_read", avm_read, 0);
        avm_readdatavalid = 1; avm_readdata = 32'hAAAA0001;
        #1;
        chk("rd0_r0_rdv", r0_readdatavalid, 1);
        chk("rd0_r1_rdv", r1_readdatavalid, 0);
        chk("rd0_r0_data", r0_readdata, 32'hAAAA0001);
        nxt();
        avm_readdatavalid = 0;
        #1;
        chk("rd1_idle_r1_waitreq", r1_waitrequest, 1);
        nxt();
        chk("rd1_avm_read", avm_read, 1);
        chk("rd1_avm_address", avm_address, 25'h200);
        chk("rd1_r1_waitreq", r1_waitrequest, 0);
        chk("rd1_r0_waitreq", r0_waitrequest, 1);
        r1_read = 0;
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'h55550002;
        #1;
        chk("rd1_r1_rdv", r1_readdatavalid, 1);
        chk("rd1_r0_rdv", r0_readdatavalid, 0);
        chk("rd1_r1_data", r1_readdata, 32'h55550002);
        nxt();
        avm_readdatavalid = 0;

        // Continuous writes from both: grants must alternate 0,1,0,1,...
        reset_reset_n = 0; nxt(); reset_reset_n = 1; nxt();
        n0 = 0; n1 = 0; g = 0;
        r0_write = 1; r0_address = 25'h1000; r1_write = 1; r1_address = 25'h2000;
        for (int c = 0; c < 60 && (n0 < 6 || n1 < 6); c++) begin
            #1;
            if (!r0_waitrequest) begin
                chk("alt_owner0", 64'(0), 64'(g % 2));
                chk("alt_addr0", avm_address, 64'(32'h1000 + n0));
                n0++; g++;
                r0_write = (n0 < 6);
                r0_address = ADDR_W'(32'h1000 + n0);
            end
            if (!r1_waitrequest) begin
                chk("alt_owner1", 64'(1), 64'(g % 2));
                chk("alt_addr1", avm_address, 64'(32'h2000 + n1));
                n1++; g++;
                r1_write = (n1 < 6);
                r1_address = ADDR_W'(32'h2000 + n1);
            end
            nxt();
        end
        r0_write = 0; r1_write = 0;
        chk("alt_count0", 64'(n0), 6);
        chk("alt_count1", 64'(n1), 6);
`ifdef SDRAM_ARB_STATS_EN
        chk("stat_grants0", stat_grants0, 6);
        chk("stat_grants1", stat_grants1, 6);
`else
        chk("stat_grants0_off", stat_grants0, 0);
        chk("stat_grants1_off", stat_grants1, 0);
`endif
        nxt();

        // r1 read stalled 5 cycles by avm_waitrequest
        r1_read = 1; r1_address = 25'h3A5; avm_waitrequest = 1;
        nxt();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) avm_readdatavalid = 1;
            #1;
            chk("stall_avm_read", avm_read, 1);
            chk("stall_avm_address", avm_address, 25'h3A5);
            chk("stall_r1_waitreq", r1_waitrequest, 1);
            if (k == 2) begin
                chk("stall_ignore_rdv1", r1_readdatavalid, 0);
                chk("stall_ignore_rdv0", r0_readdatavalid, 0);
            end
            nxt();
            avm_readdatavalid = 0;
        end
        avm_waitrequest = 0;
        #1;
        chk("stall_accept_r1_waitreq", r1_waitrequest, 0);
        chk("stall_accept_avm_address", avm_address, 25'h3A5);
        r1_read = 0;
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'h0BADF00D;
        #1;
        chk("stall_r1_rdv", r1_readdatavalid, 1);
        chk("stall_r1_data", r1_readdata, 32'h0BADF00D);
        nxt();
        avm_readdatavalid = 0;

        // Reset during RDWAIT, late response must be ignored
        r0_read = 1; r0_address = 25'h44;
        nxt();
        r0_read = 0;
        nxt();
        reset_reset_n = 0;
        #1;
        chk("midrst_avm_read", avm_read, 0);
        chk("midrst_avm_address", avm_address, 0);
        chk("midrst_r0_waitreq", r0_waitrequest, 1);
        nxt();
        reset_reset_n = 1;
        avm_readdatavalid = 1; avm_readdata = 32'h12345678;
        #1;
        chk("midrst_r0_rdv", r0_readdatavalid, 0);
        chk("midrst_r1_rdv", r1_readdatavalid, 0);
        nxt();
        avm_readdatavalid = 0;

        // Read and write together: write first, then read
        r0_read = 1; r0_write = 1; r0_address = 25'h55; r0_writedata = 32'hCAFE0055;
        nxt();
        chk("rw_first_write", avm_write, 1);
        chk("rw_first_read", avm_read, 0);
        chk("rw_first_waitreq", r0_waitrequest, 0);
        r0_write = 0;
        nxt();
        chk("rw_idle_avm_write", avm_write, 0);
        nxt();
        chk("rw_second_read", avm_read, 1);
        chk("rw_second_write", avm_write, 0);
        chk("rw_second_address", avm_address, 25'h55);
        r0_read = 0;
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'h00C0FFEE;
        #1;
        chk("rw_r0_rdv", r0_readdatavalid, 1);
        chk("rw_r0_data", r0_readdata, 32'h00C0FFEE);
        nxt();
        avm_readdatavalid = 0;
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
